doodle_motion: RTL and testbench

Per-frame vertical/horizontal kinematics for the doodle sprite, directly downstream of the collision stage. Consumes the latched ground platform (y, x), advances doodle position and velocity once per frame tick, bounces on landing, requests camera scroll when the doodle rises past the top limit, and declares game over when it falls off screen. Its `doodle_x`/`doodle_y` outputs feed back into the collision stage and the renderer.

---
 rtl/doodle_motion.sv | 148 ++++++++++++++
 tb/tb_doodle_motion.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/doodle_motion.sv
// Per-frame doodle kinematics: gravity, platform bounce, camera scroll and game over.
// Optional DOODLE_WRAP_EN: horizontal position wraps around the screen instead of clamping.
module doodle_motion #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int FLOOR_Y  = 767,
  parameter int DOODLE_H = 80,
  parameter int DOODLE_W = 100,
  parameter int START_X  = 462,
  parameter int TOP_Y    = 200,
  parameter int JUMP_V   = -20,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 15,
  parameter int H_SPEED  = 6,
  parameter int LAND_TOL = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic [9:0]        ground_y,
  input  logic [9:0]        ground_x,
  output logic [10:0]       doodle_x,
  output logic [9:0]        doodle_y,
  output logic signed [7:0] velocity,
  output logic              bounce,
  output logic              scroll_valid,
  output logic [7:0]        scroll_dy,
  output logic              game_over
);

  typedef enum logic [1:0] {S_RISE, S_FALL, S_DEAD} state_t;

  localparam logic signed [11:0] L_DH     = 12'(DOODLE_H);
  localparam logic signed [11:0] L_TOL    = 12'(LAND_TOL);
  localparam logic signed [11:0] L_TOP    = 12'(TOP_Y);
  localparam logic signed [11:0] L_BOTTOM = 12'(SCREEN_H - 1);
  localparam logic signed [7:0]  L_MF     = 8'(MAX_FALL);
  localparam logic signed [7:0]  L_G      = 8'(GRAVITY);

  state_t             r_state;
  logic [10:0]        r_x;
  logic [9:0]         r_y;
  logic signed [7:0]  r_vel;
  logic               r_bounce;
  logic               r_scroll_valid;
  logic [7:0]         r_scroll_dy;
  logic               r_game_over;
  logic               r_floor_armed;

  logic signed [11:0] w_y;
  logic signed [11:0] w_g;
  logic signed [11:0] w_ny;
  logic signed [7:0]  w_vel_nx;
  logic               w_land;
  logic               w_die;
  logic               w_unused_gx;

  function automatic logic [7:0] sat_u8(input logic signed [11:0] v);
    if (v > 12'sd255)     return 8'hFF;
    else if (v < 12'sd0)  return 8'h00;
    else                  return v[7:0];
  endfunction

  function automatic logic [10:0] step_x(input logic [10:0] x, input logic l, input logic r);
    int xi;
    xi = int'({21'b0, x});
`ifdef DOODLE_WRAP_EN
    if (l && !r)      xi = (xi < H_SPEED) ? xi + SCREEN_W - H_SPEED : xi - H_SPEED;
    else if (r && !l) xi = (xi + H_SPEED > SCREEN_W - 1) ? xi + H_SPEED - SCREEN_W : xi + H_SPEED;
`else
    if (l && !r)      xi = (xi < H_SPEED) ? 0 : xi - H_SPEED;
    else if (r && !l) xi = (xi + H_SPEED > SCREEN_W - DOODLE_W) ? SCREEN_W - DOODLE_W : xi + H_SPEED;
`endif
    return 11'(xi);
  endfunction

  assign w_unused_gx = ^ground_x;

  // Everything below is evaluated from pre-tick register values.
  assign w_y      = $signed({2'b00, r_y});
  assign w_g      = $signed({2'b00, ground_y});
  assign w_ny     = w_y + $signed({{4{r_vel[7]}}, r_vel});
  assign w_vel_nx = (r_vel >= L_MF) ? L_MF : r_vel + L_G;

  // The floor only catches the doodle until it has stood on a real platform.
  assign w_land = (r_state == S_FALL) && (w_y + L_DH <= w_g + L_TOL) && (w_ny + L_DH >= w_g) &&
                  !((ground_y == 10'(FLOOR_Y)) && !r_floor_armed);
  assign w_die  = (w_ny + L_DH > L_BOTTOM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_FALL;
      r_x            <= 11'(START_X);
      r_y            <= 10'(FLOOR_Y - DOODLE_H);
      r_vel          <= 8'sd0;
      r_bounce       <= 1'b0;
      r_scroll_valid <= 1'b0;
      r_scroll_dy    <= 8'd0;
      r_game_over    <= 1'b0;
      r_floor_armed  <= 1'b1;
    end else begin
      r_bounce       <= 1'b0;
      r_scroll_valid <= 1'b0;
      if (frame_tick && (r_state != S_DEAD)) begin
        r_x   <= step_x(r_x, btn_left, btn_right);
        r_vel <= w_vel_nx;
        case (r_state)
          S_FALL: begin
            if (w_land) begin
              r_y      <= ground_y - 10'(DOODLE_H);
              r_vel    <= 8'(JUMP_V);
              r_bounce <= 1'b1;
              r_state  <= S_RISE;
              if (ground_y != 10'(FLOOR_Y)) r_floor_armed <= 1'b0;
            end else if (w_die) begin
              r_state     <= S_DEAD;
              r_game_over <= 1'b1;
            end else begin
              r_y <= w_ny[9:0];
            end
          end
          S_RISE: begin
            if (w_ny < L_TOP) begin
              r_y            <= 10'(TOP_Y);
              r_scroll_dy    <= sat_u8(L_TOP - w_ny);
              r_scroll_valid <= 1'b1;
            end else begin
              r_y <= w_ny[9:0];
            end
            r_state <= w_vel_nx[7] ? S_RISE : S_FALL;
          end
          default: ;
        endcase
      end
    end
  end

  assign doodle_x     = r_x;
  assign doodle_y     = r_y;
  assign velocity     = r_vel;
  assign bounce       = r_bounce;
  assign scroll_valid = r_scroll_valid;
  assign scroll_dy    = r_scroll_dy;
  assign game_over    = r_game_over;

endmodule

// File: tb/tb_doodle_motion.sv
// Directed bench for doodle_motion: bounce, rise, scroll, death, reset and horizontal limits.
module tb_doodle_motion;

  logic              clk;
  logic              rst;
  logic              frame_tick;
  logic              btn_left;
  logic              btn_right;
  logic [9:0]        ground_y;
  logic [9:0]        ground_x;
  logic [10:0]       doodle_x;
  logic [9:0]        doodle_y;
  logic signed [7:0] velocity;
  logic              bounce;
  logic              scroll_valid;
  logic [7:0]        scroll_dy;
  logic              game_over;

  int n_vec;
  int n_err;
  int cnt;
  int nb;
  logic seen;

  doodle_motion dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .ground_y    (ground_y),
    .ground_x    (ground_x),
    .doodle_x    (doodle_x),
    .doodle_y    (doodle_y),
    .velocity    (velocity),
    .bounce      (bounce),
    .scroll_valid(scroll_valid),
    .scroll_dy   (scroll_dy),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    ground_y = 10'd767; ground_x = 10'd300;
    idle(); idle();
    rst = 1'b0;
    idle();

    chk("rst_y", doodle_y, 687);
    chk("rst_x", doodle_x, 462);
    chk("rst_vel", velocity, 0);
    chk("rst_bounce", bounce, 0);
    chk("rst_scroll_valid", scroll_valid, 0);
    chk("rst_scroll_dy", scroll_dy, 0);
    chk("rst_game_over", game_over, 0);

    // Floor bounce
    tick();
    chk("floor_y", doodle_y, 687);
    chk("floor_vel", velocity, -20);
    chk("floor_bounce", bounce, 1);
    idle();
    chk("floor_bounce_drop", bounce, 0);

    // Rise, then 20 more ticks into the fall
    tick();
    chk("rise1_y", doodle_y, 667);
    chk("rise1_vel", velocity, -19);
    for (int i = 0; i < 20; i++) tick();
    chk("apex_vel", velocity, 1);
    chk("apex_y", doodle_y, 477);

    // Land on a platform at 540 (disarms the floor)
    ground_y = 10'd540;
    tick();
    chk("land540_bounce", bounce, 1);
    chk("land540_y", doodle_y, 460);
    chk("land540_vel", velocity, -20);

    // Fly up and come back down onto a platform at 380
    ground_y = 10'd380;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 60) begin
      tick();
      cnt++;
      seen = bounce;
    end
    chk("land380_ticks", cnt, 31);
    chk("land380_y", doodle_y, 300);
    chk("land380_vel", velocity, -20);

    // Scroll
    for (int i = 0; i < 5; i++) tick();
    chk("pre_scroll_y", doodle_y, 210);
    chk("pre_scroll_vel", velocity, -15);
    tick();
    chk("scroll_y", doodle_y, 200);
    chk("scroll_dy", scroll_dy, 5);
    chk("scroll_valid", scroll_valid, 1);
    chk("scroll_vel", velocity, -14);
    idle();
    chk("scroll_valid_drop", scroll_valid, 0);
    chk("scroll_dy_hold", scroll_dy, 5);

    // Death: floor no longer catches
    ground_y = 10'd767;
    cnt = 0; nb = 0;
    while (!game_over && cnt < 100) begin
      tick();
      cnt++;
      if (bounce) nb++;
    end
    chk("death_ticks", cnt, 55);
    chk("death_bounces", nb, 0);
    chk("death_y", doodle_y, 680);
    chk("death_vel", velocity, 15);
    chk("death_x", doodle_x, 462);

    // Frozen when dead
    btn_right = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    btn_right = 1'b0;
    chk("dead_y", doodle_y, 680);
    chk("dead_x", doodle_x, 462);
    chk("dead_vel", velocity, 15);
    chk("dead_go", game_over, 1);
    chk("dead_bounce", bounce, 0);

    // Reset out of DEAD, together with a tick
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("dead_rst_go", game_over, 0);
    chk("dead_rst_y", doodle_y, 687);

    // Reset mid-rise with a tick and a button pressed
    tick();
    tick();
    chk("mid_rise_y", doodle_y, 667);
    rst = 1'b1; btn_left = 1'b1;
    tick();
    rst = 1'b0; btn_left = 1'b0;
    chk("mid_rst_y", doodle_y, 687);
    chk("mid_rst_x", doodle_x, 462);
    chk("mid_rst_vel", velocity, 0);
    chk("mid_rst_go", game_over, 0);
    chk("mid_rst_bounce", bounce, 0);

    // Horizontal limits while bouncing on the armed floor
    btn_left = 1'b1;
    for (int i = 0; i < 77; i++) tick();
    chk("left_77", doodle_x, 0);
    tick();
`ifdef DOODLE_WRAP_EN
    chk("left_edge", doodle_x, 1018);
`else
    chk("left_edge", doodle_x, 0);
`endif
    tick(); tick();
    btn_right = 1'b1;
    for (int i = 0; i < 3; i++) tick();
`ifdef DOODLE_WRAP_EN
    chk("both_hold", doodle_x, 1006);
`else
    chk("both_hold", doodle_x, 0);
`endif
    btn_left = 1'b0;
    for (int i = 0; i < 160; i++) tick();
    btn_right = 1'b0;
`ifdef DOODLE_WRAP_EN
    chk("right_edge", doodle_x, 942);
`else
    chk("right_edge", doodle_x, 924);
`endif
    chk("floor_alive", game_over, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
